// File: rtl/ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_pkg                                                                 |
// | Control-bundle layout, ALUOp and forwarding encodings, bubble values.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package ctrl_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 4;
    localparam int EX_W = 5;

    localparam int REGWRITE_B = 0;
    localparam int MEMTOREG_B = 1;
    localparam int BRANCH_B   = 0;
    localparam int MEMREAD_B  = 1;
    localparam int MEMWRITE_B = 2;
    localparam int JUMP_B     = 3;
    localparam int REGDST_B   = 0;
    localparam int ALUSRC_B   = 4;
    localparam int ALUOP_LSB  = 1;
    localparam int ALUOP_W    = 3;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD   = 3'b000,
        ALUOP_SUB   = 3'b001,
        ALUOP_RTYPE = 3'b010,
        ALUOP_SLT   = 3'b011,
        ALUOP_AND   = 3'b100,
        ALUOP_OR    = 3'b101
    } aluop_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_e;

    // Jump is resolved in ID, so only the three memory-stage strobes travel on.
    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } wb_ctl_t;

    typedef struct packed {
        logic memwrite;
        logic memread;
        logic branch;
    } m_ctl_t;

    localparam wb_ctl_t         BUBBLE_WB = '0;
    localparam m_ctl_t          BUBBLE_M  = '0;
    localparam logic [EX_W-1:0] BUBBLE_EX = '0;

endpackage
`default_nettype wire

// File: rtl/ctrl_pipeline_hazard_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_detect                                                            |
// | Combinational stall decision (and forwarding selects with FORWARDING_EN).|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hazard_detect
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  id_nop_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic [REG_ADDR_W-1:0] ex_dst_i,
    input  logic                  ex_regwrite_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] mem_dst_i,
    input  logic                  mem_regwrite_i,
`ifdef FORWARDING_EN
    input  logic [REG_ADDR_W-1:0] ex_rs_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    input  logic [REG_ADDR_W-1:0] wb_dst_i,
    input  logic                  wb_regwrite_i,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
`endif
    output logic                  stall_o
);

    function automatic logic src_hit(input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst,
                                     input logic                  rw);
        return (src != '0) && rw && (src == dst);
    endfunction

    logic w_ex_hit;
    logic w_load_use;

    always_comb begin
        w_ex_hit   = src_hit(id_rs_i, ex_dst_i, ex_regwrite_i) |
                     src_hit(id_rt_i, ex_dst_i, ex_regwrite_i);
        w_load_use = ex_memread_i & w_ex_hit;
`ifdef FORWARDING_EN
        stall_o = ~id_nop_i & w_load_use;
        fwd_a_o = FWD_RF;
        fwd_b_o = FWD_RF;
        if (src_hit(ex_rs_i, mem_dst_i, mem_regwrite_i))     fwd_a_o = FWD_EXMEM;
        else if (src_hit(ex_rs_i, wb_dst_i, wb_regwrite_i))  fwd_a_o = FWD_MEMWB;
        if (src_hit(ex_rt_i, mem_dst_i, mem_regwrite_i))     fwd_b_o = FWD_EXMEM;
        else if (src_hit(ex_rt_i, wb_dst_i, wb_regwrite_i))  fwd_b_o = FWD_MEMWB;
`else
        // Write-before-read register file: a producer already in WB is safe.
        stall_o = ~id_nop_i & (w_load_use | w_ex_hit |
                  src_hit(id_rs_i, mem_dst_i, mem_regwrite_i) |
                  src_hit(id_rt_i, mem_dst_i, mem_regwrite_i));
`endif
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_pipeline                                                            |
// | ID/EX, EX/MEM, MEM/WB control registers with stall, bubble and flush.    |
// | Optional macro FORWARDING_EN adds FWD_A/FWD_B and load-use-only stalls.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [WB_W-1:0]       ID_WB,
    input  logic [M_W-1:0]        ID_M,
    input  logic [EX_W-1:0]       ID_EX,
    input  logic                  ID_NOP,
    input  logic [REG_ADDR_W-1:0] ID_RS,
    input  logic [REG_ADDR_W-1:0] ID_RT,
    input  logic [REG_ADDR_W-1:0] ID_RD,
    input  logic                  MEM_ZERO,
    output logic                  EX_REGDST,
    output logic [ALUOP_W-1:0]    EX_ALUOP,
    output logic                  EX_ALUSRC,
    output logic                  MEM_MEMREAD,
    output logic                  MEM_MEMWRITE,
    output logic                  WB_REGWRITE,
    output logic                  WB_MEMTOREG,
    output logic [REG_ADDR_W-1:0] WB_DST,
    output logic                  PC_WRITE,
    output logic                  IFID_WRITE,
    output logic                  IFID_FLUSH,
    output logic                  PC_SRC_BRANCH,
`ifdef FORWARDING_EN
    output logic [1:0]            FWD_A,
    output logic [1:0]            FWD_B,
`endif
    output logic                  PC_SRC_JUMP
);

    wb_ctl_t                 idex_wb_q,  idex_wb_d;
    m_ctl_t                  idex_m_q,   idex_m_d;
    logic [EX_W-1:0]         idex_ex_q,  idex_ex_d;
    logic [REG_ADDR_W-1:0]   idex_dst_q, idex_dst_d;
`ifdef FORWARDING_EN
    logic [REG_ADDR_W-1:0]   idex_rs_q,  idex_rs_d;
    logic [REG_ADDR_W-1:0]   idex_rt_q,  idex_rt_d;
`endif
    wb_ctl_t                 exmem_wb_q,  exmem_wb_d;
    m_ctl_t                  exmem_m_q,   exmem_m_d;
    logic [REG_ADDR_W-1:0]   exmem_dst_q, exmem_dst_d;
    wb_ctl_t                 memwb_wb_q;
    logic [REG_ADDR_W-1:0]   memwb_dst_q;

    logic w_hz_stall;
    logic w_taken;
    logic w_stall;
    logic w_jump;
    logic w_bubble;

    hazard_detect #(
        .REG_ADDR_W     (REG_ADDR_W)
    ) u_hazard (
        .id_nop_i       (ID_NOP),
        .id_rs_i        (ID_RS),
        .id_rt_i        (ID_RT),
        .ex_dst_i       (idex_dst_q),
        .ex_regwrite_i  (idex_wb_q.regwrite),
        .ex_memread_i   (idex_m_q.memread),
        .mem_dst_i      (exmem_dst_q),
        .mem_regwrite_i (exmem_wb_q.regwrite),
`ifdef FORWARDING_EN
        .ex_rs_i        (idex_rs_q),
        .ex_rt_i        (idex_rt_q),
        .wb_dst_i       (memwb_dst_q),
        .wb_regwrite_i  (memwb_wb_q.regwrite),
        .fwd_a_o        (FWD_A),
        .fwd_b_o        (FWD_B),
`endif
        .stall_o        (w_hz_stall)
    );

    always_comb begin
        // Priority: taken branch, then stall, then jump.
        w_taken  = exmem_m_q.branch & MEM_ZERO;
        w_stall  = w_hz_stall & ~w_taken;
        w_jump   = ID_M[JUMP_B] & ~ID_NOP & ~w_stall & ~w_taken;
        w_bubble = ID_NOP | w_stall | w_taken | w_jump;

        idex_wb_d  = BUBBLE_WB;
        idex_m_d   = BUBBLE_M;
        idex_ex_d  = BUBBLE_EX;
        idex_dst_d = '0;
`ifdef FORWARDING_EN
        idex_rs_d  = '0;
        idex_rt_d  = '0;
`endif
        if (!w_bubble) begin
            idex_wb_d.regwrite = ID_WB[REGWRITE_B];
            idex_wb_d.memtoreg = ID_WB[MEMTOREG_B];
            idex_m_d.branch    = ID_M[BRANCH_B];
            idex_m_d.memread   = ID_M[MEMREAD_B];
            idex_m_d.memwrite  = ID_M[MEMWRITE_B];
            idex_ex_d          = ID_EX;
            // A zero dst on non-writers keeps them invisible to hazard matching.
            if (ID_WB[REGWRITE_B]) begin
                idex_dst_d = ID_EX[REGDST_B] ? ID_RD : ID_RT;
            end
`ifdef FORWARDING_EN
            idex_rs_d = ID_RS;
            idex_rt_d = ID_RT;
`endif
        end

        exmem_wb_d  = w_taken ? BUBBLE_WB : idex_wb_q;
        exmem_m_d   = w_taken ? BUBBLE_M  : idex_m_q;
        exmem_dst_d = w_taken ? '0        : idex_dst_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idex_wb_q   <= BUBBLE_WB;
            idex_m_q    <= BUBBLE_M;
            idex_ex_q   <= BUBBLE_EX;
            idex_dst_q  <= '0;
`ifdef FORWARDING_EN
            idex_rs_q   <= '0;
            idex_rt_q   <= '0;
`endif
            exmem_wb_q  <= BUBBLE_WB;
            exmem_m_q   <= BUBBLE_M;
            exmem_dst_q <= '0;
            memwb_wb_q  <= BUBBLE_WB;
            memwb_dst_q <= '0;
        end else begin
            idex_wb_q   <= idex_wb_d;
            idex_m_q    <= idex_m_d;
            idex_ex_q   <= idex_ex_d;
            idex_dst_q  <= idex_dst_d;
`ifdef FORWARDING_EN
            idex_rs_q   <= idex_rs_d;
            idex_rt_q   <= idex_rt_d;
`endif
            exmem_wb_q  <= exmem_wb_d;
            exmem_m_q   <= exmem_m_d;
            exmem_dst_q <= exmem_dst_d;
            memwb_wb_q  <= exmem_wb_q;
            memwb_dst_q <= exmem_dst_q;
        end
    end

    assign EX_REGDST     = idex_ex_q[REGDST_B];
    assign EX_ALUOP      = idex_ex_q[ALUOP_LSB +: ALUOP_W];
    assign EX_ALUSRC     = idex_ex_q[ALUSRC_B];
    assign MEM_MEMREAD   = exmem_m_q.memread;
    assign MEM_MEMWRITE  = exmem_m_q.memwrite;
    assign WB_REGWRITE   = memwb_wb_q.regwrite;
    assign WB_MEMTOREG   = memwb_wb_q.memtoreg;
    assign WB_DST        = memwb_dst_q;
    assign PC_WRITE      = ~w_stall;
    assign IFID_WRITE    = ~w_stall;
    assign IFID_FLUSH    = w_taken | w_jump;
    assign PC_SRC_BRANCH = w_taken;
    assign PC_SRC_JUMP   = w_jump;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ctrl_pipeline                                                         |
// | Directed scenarios plus random instruction streams against a stage model.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ctrl_pipeline;
    import ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [1:0] ID_WB;
    logic [3:0] ID_M;
    logic [4:0] ID_EX;
    logic       ID_NOP;
    logic [4:0] ID_RS, ID_RT, ID_RD;
    logic       MEM_ZERO;
    logic       EX_REGDST, EX_ALUSRC, MEM_MEMREAD, MEM_MEMWRITE;
    logic [2:0] EX_ALUOP;
    logic       WB_REGWRITE, WB_MEMTOREG;
    logic [4:0] WB_DST;
    logic       PC_WRITE, IFID_WRITE, IFID_FLUSH, PC_SRC_BRANCH, PC_SRC_JUMP;
`ifdef FORWARDING_EN
    logic [1:0] FWD_A, FWD_B;
    localparam int LU_STALLS = 1;
`else
    localparam int LU_STALLS = 2;   // load-use cycle plus the MEM-stage RAW cycle
`endif

    ctrl_pipeline #(.REG_ADDR_W(5)) dut (
        .CLK(CLK), .RST_N(RST_N), .ID_WB(ID_WB), .ID_M(ID_M), .ID_EX(ID_EX),
        .ID_NOP(ID_NOP), .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_RD(ID_RD),
        .MEM_ZERO(MEM_ZERO), .EX_REGDST(EX_REGDST), .EX_ALUOP(EX_ALUOP),
        .EX_ALUSRC(EX_ALUSRC), .MEM_MEMREAD(MEM_MEMREAD), .MEM_MEMWRITE(MEM_MEMWRITE),
        .WB_REGWRITE(WB_REGWRITE), .WB_MEMTOREG(WB_MEMTOREG), .WB_DST(WB_DST),
        .PC_WRITE(PC_WRITE), .IFID_WRITE(IFID_WRITE), .IFID_FLUSH(IFID_FLUSH),
        .PC_SRC_BRANCH(PC_SRC_BRANCH),
`ifdef FORWARDING_EN
        .FWD_A(FWD_A), .FWD_B(FWD_B),
`endif
        .PC_SRC_JUMP(PC_SRC_JUMP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rw, mtr, br, mr, mw, rdst, alusrc;
        logic [2:0] op;
        logic [4:0] dst, rs, rt;
    } ins_t;

    localparam logic [18:0] IDLE = 19'h18;   // only PC_WRITE and IFID_WRITE high

    ins_t bub = '{default: '0};
    ins_t st[3];                             // [0]=EX, [1]=MEM, [2]=WB
    ins_t exp_new;
    logic exp_taken, exp_stall, exp_jump;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic hit(input logic [4:0] r, input ins_t s);
        return (r != 5'd0) && s.rw && (s.dst == r);
    endfunction

`ifdef FORWARDING_EN
    function automatic logic [1:0] fwd(input logic [4:0] r);
        if (hit(r, st[1])) return 2'b10;
        if (hit(r, st[2])) return 2'b01;
        return 2'b00;
    endfunction
`endif

    function automatic logic [18:0] outs();
        return {EX_REGDST, EX_ALUOP, EX_ALUSRC, MEM_MEMREAD, MEM_MEMWRITE,
                WB_REGWRITE, WB_MEMTOREG, WB_DST, PC_WRITE, IFID_WRITE,
                IFID_FLUSH, PC_SRC_BRANCH, PC_SRC_JUMP};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) st[i] = bub;
    endtask

    task automatic model_eval();
        logic hz;
        hz        = 1'b0;
        exp_taken = st[1].br && MEM_ZERO;
        if (!ID_NOP) begin
`ifdef FORWARDING_EN
            hz = st[0].mr && (hit(ID_RS, st[0]) || hit(ID_RT, st[0]));
`else
            hz = hit(ID_RS, st[0]) || hit(ID_RT, st[0]) ||
                 hit(ID_RS, st[1]) || hit(ID_RT, st[1]);
`endif
        end
        exp_stall = hz && !exp_taken;
        exp_jump  = !ID_NOP && ID_M[3] && !exp_stall && !exp_taken;
        exp_new   = bub;
        if (!(ID_NOP || exp_stall || exp_taken || exp_jump)) begin
            exp_new.rw     = ID_WB[0];
            exp_new.mtr    = ID_WB[1];
            exp_new.br     = ID_M[0];
            exp_new.mr     = ID_M[1];
            exp_new.mw     = ID_M[2];
            exp_new.rdst   = ID_EX[0];
            exp_new.op     = ID_EX[3:1];
            exp_new.alusrc = ID_EX[4];
            exp_new.dst    = ID_WB[0] ? (ID_EX[0] ? ID_RD : ID_RT) : 5'd0;
            exp_new.rs     = ID_RS;
            exp_new.rt     = ID_RT;
        end
    endtask

    // Compare every output with the model, then advance one clock.
    task automatic cycle();
        model_eval();
        check("ex_regdst",     EX_REGDST,     st[0].rdst);
        check("ex_aluop",      EX_ALUOP,      st[0].op);
        check("ex_alusrc",     EX_ALUSRC,     st[0].alusrc);
        check("mem_memread",   MEM_MEMREAD,   st[1].mr);
        check("mem_memwrite",  MEM_MEMWRITE,  st[1].mw);
        check("wb_regwrite",   WB_REGWRITE,   st[2].rw);
        check("wb_memtoreg",   WB_MEMTOREG,   st[2].mtr);
        check("wb_dst",        WB_DST,        st[2].dst);
        check("pc_write",      PC_WRITE,      !exp_stall);
        check("ifid_write",    IFID_WRITE,    !exp_stall);
        check("ifid_flush",    IFID_FLUSH,    exp_taken || exp_jump);
        check("pc_src_branch", PC_SRC_BRANCH, exp_taken);
        check("pc_src_jump",   PC_SRC_JUMP,   exp_jump);
`ifdef FORWARDING_EN
        check("fwd_a", FWD_A, fwd(st[0].rs));
        check("fwd_b", FWD_B, fwd(st[0].rt));
`endif
        st[2] = st[1];
        st[1] = exp_taken ? bub : st[0];
        st[0] = exp_new;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [3:0] m, input logic [4:0] ex,
                         input logic nop, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        ID_WB = wb; ID_M = m; ID_EX = ex; ID_NOP = nop;
        ID_RS = rs; ID_RT = rt; ID_RD = rd;
        #1;
    endtask

    task automatic i_nop();                  drive(2'b00, 4'b0000, 5'b0, 1'b1, 5'd0, 5'd0, 5'd0); endtask
    task automatic i_lw(input logic [4:0] rs, input logic [4:0] rt);
        drive(2'b11, 4'b0010, {1'b1, ALUOP_ADD, 1'b0}, 1'b0, rs, rt, 5'd0);
    endtask
    task automatic i_sw(input logic [4:0] rs, input logic [4:0] rt);
        drive(2'b00, 4'b0100, {1'b1, ALUOP_ADD, 1'b0}, 1'b0, rs, rt, 5'd0);
    endtask
    task automatic i_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        drive(2'b01, 4'b0000, {1'b0, ALUOP_RTYPE, 1'b1}, 1'b0, rs, rt, rd);
    endtask
    task automatic i_beq(input logic [4:0] rs, input logic [4:0] rt);
        drive(2'b00, 4'b0001, {1'b0, ALUOP_SUB, 1'b0}, 1'b0, rs, rt, 5'd0);
    endtask
    task automatic i_j(input logic [4:0] rs);
        drive(2'b00, 4'b1000, 5'b0, 1'b0, rs, 5'd0, 5'd0);
    endtask
    task automatic drain();
        repeat (3) begin i_nop(); cycle(); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        RST_N = 1'b0; MEM_ZERO = 1'b0;
        ID_WB = '0; ID_M = '0; ID_EX = '0; ID_NOP = 1'b1; ID_RS = '0; ID_RT = '0; ID_RD = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", outs(), IDLE);
        @(negedge CLK); RST_N = 1'b1;
        @(posedge CLK); #1;

        // LW through all three stages
        i_lw(5'd9, 5'd8); cycle();
        i_nop();
        check("lw_ex_alusrc", EX_ALUSRC, 1'b1);
        check("lw_ex_aluop",  EX_ALUOP,  ALUOP_ADD);
        cycle();
        check("lw_mem_memread", MEM_MEMREAD, 1'b1);
        cycle();
        check("lw_wb_regwrite", WB_REGWRITE, 1'b1);
        check("lw_wb_memtoreg", WB_MEMTOREG, 1'b1);
        check("lw_wb_dst",      WB_DST,      5'd8);
        drain();

        // Load-use
        i_lw(5'd9, 5'd8); cycle();
        i_add(5'd8, 5'd10, 5'd11);
        n = 0;
        while (PC_WRITE == 1'b0 && n < 4) begin
            check("lu_ifid_write", IFID_WRITE, 1'b0);
            n++;
            cycle();
            if (n == 1) check("lu_bubble_in_ex", {EX_REGDST, EX_ALUOP, EX_ALUSRC}, 5'd0);
        end
        check("lu_stall_cycles", n, LU_STALLS);
        cycle();
        check("lu_add_in_ex", EX_ALUOP, ALUOP_RTYPE);
        drain();

        // Taken branch flushes the younger SW in EX and the ADD in ID
        i_beq(5'd1, 5'd2); cycle();
        i_sw(5'd3, 5'd4);  cycle();
        i_add(5'd1, 5'd2, 5'd5);
        MEM_ZERO = 1'b1; #1;
        check("br_taken",    PC_SRC_BRANCH, 1'b1);
        check("br_flush",    IFID_FLUSH,    1'b1);
        check("br_pc_write", PC_WRITE,      1'b1);
        cycle();
        MEM_ZERO = 1'b0;
        check("br_ex_cleared",  {EX_REGDST, EX_ALUOP, EX_ALUSRC}, 5'd0);
        check("br_mem_cleared", {MEM_MEMREAD, MEM_MEMWRITE},      2'd0);
        drain();

        // Same sequence, branch not taken
        i_beq(5'd1, 5'd2); cycle();
        i_sw(5'd3, 5'd4);  cycle();
        i_add(5'd1, 5'd2, 5'd5);
        check("nbr_taken", PC_SRC_BRANCH, 1'b0);
        check("nbr_flush", IFID_FLUSH,    1'b0);
        cycle();
        check("nbr_sw_in_mem", MEM_MEMWRITE, 1'b1);
        check("nbr_add_in_ex", EX_ALUOP,     ALUOP_RTYPE);
        drain();

        // Jump held by a load-use stall, then taken
        i_lw(5'd9, 5'd8); cycle();
        i_j(5'd8);
        check("jmp_held",        PC_SRC_JUMP, 1'b0);
        check("jmp_held_stall",  PC_WRITE,    1'b0);
        n = 0;
        while (PC_WRITE == 1'b0 && n < 4) begin n++; cycle(); end
        check("jmp_taken", PC_SRC_JUMP, 1'b1);
        check("jmp_flush", IFID_FLUSH,  1'b1);
        cycle();
        i_nop();
        check("jmp_bubble_ex", {EX_REGDST, EX_ALUOP, EX_ALUSRC}, 5'd0);
        drain();

        // NOP with unknown bundle
        repeat (3) begin
            drive('x, 'x, 'x, 1'b1, 'x, 'x, 'x);
            check("nop_x_outputs", outs(), IDLE);
            cycle();
        end

        // Writer of $0 followed by a reader of $0
        i_add(5'd1, 5'd2, 5'd0); cycle();
        i_add(5'd0, 5'd0, 5'd4);
        check("r0_no_stall", PC_WRITE, 1'b1);
        cycle();
        drain();

        // Asynchronous reset with three instructions in flight
        i_lw(5'd9, 5'd8);        cycle();
        i_add(5'd1, 5'd2, 5'd3); cycle();
        i_sw(5'd4, 5'd5);        cycle();
        i_nop();
        check("inflight_wb_regwrite", WB_REGWRITE, 1'b1);
        #1; RST_N = 1'b0; #1;
        check("async_reset_clear", outs(), IDLE);
        model_reset();
        @(negedge CLK); RST_N = 1'b1;
        @(posedge CLK); #1;
        repeat (3) begin
            i_nop();
            check("post_reset_empty", outs(), IDLE);
            cycle();
        end

        // Random instruction streams over a small register set
        repeat (400) begin
            MEM_ZERO = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1:    drive(2'($urandom), 4'($urandom), 5'($urandom), 1'b1,
                               5'($urandom), 5'($urandom), 5'($urandom));
                2, 3, 8: i_add(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                               5'($urandom_range(0, 3)));
                4:       i_lw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                5:       i_sw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                6:       i_beq(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
                default: i_j(5'($urandom_range(0, 3)));
            endcase
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Consumer end of the decode-stage control bundle interface: WB[1:0], M[3:0] and EX[4:0] as produced by instruction decode.
- Carries each bundle through the ID/EX, EX/MEM and MEM/WB registers of the 5-stage MIPS pipeline, presenting per-stage control to the datapath.
- Detects load-use and RAW hazards, inserts bubbles, and flushes younger instructions on a taken branch or a jump.

Parameters:
- REG_ADDR_W, 5, register-index width.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ID_WB  in  2  [0] RegWrite, [1] MemToReg.
- ID_M  in  4  [0] Branch, [1] MemRead, [2] MemWrite, [3] Jump.
- ID_EX  in  5  [0] RegDst, [3:1] ALUOp, [4] ALUSrc.
- ID_NOP  in  1  decode word is all-zero; bundle content is ignored.
- ID_RS, ID_RT, ID_RD  in  REG_ADDR_W  register fields of the decode instruction.
- MEM_ZERO  in  1  ALU zero flag of the instruction in MEM.
- EX_REGDST  out  1  RegDst for the EX instruction.
- EX_ALUOP  out  3  ALUOp for the EX instruction.
- EX_ALUSRC  out  1  ALUSrc for the EX instruction.
- MEM_MEMREAD, MEM_MEMWRITE  out  1  memory strobes for the MEM instruction.
- WB_REGWRITE, WB_MEMTOREG  out  1  write-back controls.
- WB_DST  out  REG_ADDR_W  write-back destination register.
- PC_WRITE, IFID_WRITE  out  1  low while stalled.
- IFID_FLUSH  out  1  clear IF/ID.
- PC_SRC_BRANCH  out  1  MEM Branch & MEM_ZERO.
- PC_SRC_JUMP  out  1  jump taken from ID.

Behaviour:
- Reset (asynchronous, RST_N low): all stage registers clear to zero; all outputs 0 except PC_WRITE=1 and IFID_WRITE=1.
- Bubble: WB=0, M=0, EX=0, dst=0. A bubble is inserted into ID/EX when any of the following holds:
  - ID_NOP=1
  - a stall is active
  - a flush is active
- Capture into ID/EX: the WB and M fields of a non-bubble are registered as given. The EX field is registered as given. Any x in an EX field is irrelevant when RegWrite=0.
- Destination select in ID/EX: dst = RegDst ? ID_RD : ID_RT. When RegWrite=0, dst is forced to 0.
- Advance: EX/MEM takes ID/EX every cycle, and MEM/WB takes EX/MEM every cycle. Only ID/EX is ever replaced by a bubble on a stall.
- Latency: decode bundle to EX outputs is 1 cycle, to MEM outputs 2 cycles, to WB outputs 3 cycles.
- Hazard match: a source matches when it is nonzero, equals a stage dst, and that stage has RegWrite=1. Register 0 never causes a hazard.
- Load-use: the EX instruction has MemRead=1 and its dst matches ID_RS or ID_RT. Result: stall for 1 cycle.
- Stall: PC_WRITE=0, IFID_WRITE=0, bubble into ID/EX.
- Taken branch: PC_SRC_BRANCH = MEM Branch & MEM_ZERO, combinational. That same cycle:
  - IFID_FLUSH=1
  - ID/EX and EX/MEM load bubbles on the next edge
  - stall is suppressed (PC_WRITE=1)
- Jump: ID_M[3]=1, ID_NOP=0 and no stall. Then PC_SRC_JUMP=1 and IFID_FLUSH=1; the jump itself passes into ID/EX as a bubble-equivalent.
- Priority: taken branch > stall > jump.
  - Jump with a simultaneous stall: PC_SRC_JUMP=0 and the jump is retried next cycle.
  - Jump with a simultaneous taken branch: the jump is discarded.
- Reset mid-operation: all in-flight bundles are discarded immediately (asynchronous clear).

Optional Feature:
- Macro FORWARDING_EN.
- Defined: adds outputs FWD_A and FWD_B (2 bits each) for the EX instruction's rs/rt, which ID/EX must also register.
  - 2'b10 = forward from EX/MEM (priority); 2'b01 = forward from MEM/WB; 2'b00 = register file.
  - Only the load-use case stalls.
- Undefined: no FWD ports. Stall additionally when ID_RS or ID_RT matches the EX-stage or MEM-stage dst with RegWrite=1. The register file is write-before-read, so the WB stage needs no stall.

Decomposition:
- Package ctrl_pkg contains:
  - widths of the WB, M and EX bundles;
  - bit-index constants (REGWRITE_B, MEMTOREG_B, BRANCH_B, MEMREAD_B, MEMWRITE_B, JUMP_B, REGDST_B, ALUSRC_B);
  - ALUOp encodings: ADD 000, SUB 001, RTYPE 010, SLT 011, AND 100, OR 101;
  - the BUBBLE constants.
- One sub-module, hazard_detect: purely combinational. Takes the ID sources and the EX/MEM dst, RegWrite and MemRead; produces the stall signal and, under FORWARDING_EN, FWD_A/FWD_B.

Test Plan:
- Reset, then feed LW (WB=11, M=0010, EX=10000, rt=8). At cycle 1: EX_ALUSRC=1, EX_ALUOP=000. Cycle 2: MEM_MEMREAD=1. Cycle 3: WB_REGWRITE=1, WB_MEMTOREG=1, WB_DST=8.
- LW to $8 followed by ADD reading $8: exactly 1 cycle with PC_WRITE=0 and IFID_WRITE=0; a bubble reaches EX; the ADD then reaches EX with EX_ALUOP=010.
- BEQ in MEM with MEM_ZERO=1: PC_SRC_BRANCH=1 and IFID_FLUSH=1; the next cycle EX and MEM controls are all 0. Repeat with MEM_ZERO=0: no flush.
- Jump in ID together with a load-use stall: PC_SRC_JUMP=0 that cycle, then 1 the next cycle with IFID_FLUSH=1.
- ID_NOP=1 with x on the bundle inputs: every output stays 0/known for 3 cycles. Separately, ADD writing $0 followed by a reader of $0 produces no stall.
- RST_N low mid-stream with 3 instructions in flight: all outputs clear immediately (without waiting for a clock edge); after release, the pipeline is empty.
